instruction_issuer: RTL and testbench

//  Initiator side of the processor op interface (rs1/rs2/rd_in/op_code).

---
 rtl/instruction_issuer.sv | 139 +++++++++++++
 tb/tb_instruction_issuer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issuer.sv
// Fetch/decode/issue sequencer driving the datapath op interface.
// One instruction in flight; the PC advances only after op_done.
module instruction_issuer #(
    parameter int WORDSIZE = 64,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_rd_en,
    input  logic [31:0]         imem_rdata,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [WORDSIZE-1:0] rd_in,
    output logic [6:0]          op_code,
    output logic                op_valid,
    input  logic                op_done,
    output logic                busy,
    output logic                halted,
    output logic [7:0]          illegal_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] ISSUE  = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;

    localparam logic [6:0] OP_NONE  = 7'd0;
    localparam logic [6:0] OP_STORE = 7'd1;
    localparam logic [6:0] OP_ADD   = 7'd2;
    localparam logic [6:0] OP_SUB   = 7'd3;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         ir;

    logic        is_halt;
    logic        is_alu;
    logic        is_add;
    logic        is_sub;
    logic        is_sd;
    logic [11:0] s_imm;

    assign is_halt = (ir == 32'h0000_0000) || (ir == 32'h0010_0073);
    assign is_alu  = (ir[6:0] == 7'b0110011) && (ir[14:12] == 3'b000);
    assign is_add  = is_alu && (ir[31:25] == 7'b0000000);
    assign is_sub  = is_alu && (ir[31:25] == 7'b0100000);
    assign is_sd   = (ir[6:0] == 7'b0100011) && (ir[14:12] == 3'b011);
    assign s_imm   = {ir[31:25], ir[11:7]};

    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, HALT: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = WAIT;
            WAIT:       state_nxt = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_halt:                state_nxt = HALT;
                    is_add, is_sub, is_sd:  state_nxt = ISSUE;
                    default:                state_nxt = NEXT;
                endcase
            end
            ISSUE:      if (op_done) state_nxt = NEXT;
            NEXT:       state_nxt = FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status and strobe outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            imem_rd_en  <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            rd_in       <= '0;
            op_code     <= OP_NONE;
            op_valid    <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state      <= state_nxt;
            imem_rd_en <= (state_nxt == FETCH);
            op_valid   <= (state_nxt == ISSUE);
            halted     <= (state_nxt == HALT);
            busy       <= (state_nxt != IDLE) && (state_nxt != HALT);

            if ((state == IDLE || state == HALT) && start)
                pc <= '0;
            if (state == NEXT)
                pc <= pc + PC_WIDTH'(1);
            if (state == WAIT)
                ir <= imem_rdata;

            if (state == DECODE) begin
                unique case (1'b1)
                    is_halt: begin
                    end
                    is_add, is_sub: begin
                        rs1     <= ir[19:15];
                        rs2     <= ir[24:20];
                        rd      <= ir[11:7];
                        rd_in   <= '0;
                        op_code <= is_add ? OP_ADD : OP_SUB;
                    end
                    is_sd: begin
                        rs1     <= ir[24:20];
                        rs2     <= '0;
                        rd      <= ir[19:15];
                        rd_in   <= {{(WORDSIZE-12){s_imm[11]}}, s_imm};
                        op_code <= OP_STORE;
                    end
                    default: begin
                        if (illegal_cnt != 8'hFF)
                            illegal_cnt <= illegal_cnt + 8'd1;
                    end
                endcase
            end

            // Fields keep their last value; only the op code is cleared.
            if (state == ISSUE && op_done)
                op_code <= OP_NONE;
        end
    end

endmodule

// File: tb/tb_instruction_issuer.sv
// Scoreboard bench for instruction_issuer: a program-level reference
// model queues expected ops, a monitor checks each issued op.
module tb_instruction_issuer;

    localparam int WS = 64;
    localparam int PW = 2;
    localparam int NW = 4;
    localparam int K_HALT = 0;
    localparam int K_ILL  = 1;
    localparam int K_OP   = 2;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [6:0]  op;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [31:0]   imem_rdata = '0;
    logic [4:0]    rs1, rs2, rd;
    logic [WS-1:0] rd_in;
    logic [6:0]    op_code;
    logic          op_valid;
    logic          op_done;
    logic          busy;
    logic          halted;
    logic [7:0]    illegal_cnt;

    logic [31:0] mem [NW];
    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          model_ill = 0;
    int          exp_pc = 0;
    int          last_len = 0;
    bit          resp_en = 1'b1;
    bit          rand_spur = 1'b0;
    int          fixed_dly = -1;
    int          spur_req = 0;

    instruction_issuer #(.WORDSIZE(WS), .PC_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_rdata(imem_rdata),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_in(rd_in),
        .op_code(op_code), .op_valid(op_valid), .op_done(op_done),
        .busy(busy), .halted(halted), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_rd_en) imem_rdata <= mem[imem_addr];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int decode_word(input logic [31:0] w,
                                       output exp_t e);
        int unsigned u;
        int opc, f3, f7, fd, f1, f2;
        longint imm;
        u = w;
        e = '0;
        opc = int'(u % 128);
        fd  = int'((u / 128) % 32);
        f3  = int'((u / 4096) % 8);
        f1  = int'((u / 32768) % 32);
        f2  = int'((u / 1048576) % 32);
        f7  = int'(u / 33554432);
        if (u == 0 || u == 32'h0010_0073) return K_HALT;
        if (opc == 51 && f3 == 0 && (f7 == 0 || f7 == 32)) begin
            e.rs1 = 5'(f1);
            e.rs2 = 5'(f2);
            e.rd  = 5'(fd);
            e.imm = 64'd0;
            e.op  = (f7 == 0) ? 7'd2 : 7'd3;
            return K_OP;
        end
        if (opc == 35 && f3 == 3) begin
            imm = longint'(f7 * 32 + fd);
            if (imm >= 2048) imm = imm - 4096;
            e.rs1 = 5'(f2);
            e.rs2 = 5'd0;
            e.rd  = 5'(f1);
            e.imm = 64'(imm);
            e.op  = 7'd1;
            return K_OP;
        end
        return K_ILL;
    endfunction

    // Walk the program as the spec describes it and queue expectations.
    task automatic model_prog();
        int p = 0;
        int k;
        exp_t e;
        for (int s = 0; s < 400; s++) begin
            k = decode_word(mem[p], e);
            if (k == K_HALT) break;
            if (k == K_ILL) begin
                if (model_ill < 255) model_ill++;
            end else begin
                exp_q.push_back(e);
            end
            p = (p + 1) % NW;
        end
        exp_pc = p;
    endtask

    function automatic logic [31:0] rand_word();
        logic [4:0]  a, b, c;
        logic [11:0] im;
        logic [2:0]  f3;
        a  = 5'($urandom);
        b  = 5'($urandom);
        c  = 5'($urandom);
        im = 12'($urandom);
        f3 = 3'($urandom_range(1, 7));
        case ($urandom_range(0, 7))
            0, 1: return {7'h00, b, a, 3'b000, c, 7'h33};
            2:    return {7'h20, b, a, 3'b000, c, 7'h33};
            3, 4: return {im[11:5], b, a, 3'b011, im[4:0], 7'h23};
            5:    return 32'($urandom);
            6:    return {7'h00, b, a, f3, c, 7'h33};
            default: return ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0;
        endcase
    endfunction

    // Datapath responder: completes ops after a delay, injects stray pulses.
    initial begin
        int wait_cnt;
        int dly_cur;
        int spur_done;
        bit in_op;
        wait_cnt = 0;
        dly_cur = 0;
        spur_done = 0;
        in_op = 1'b0;
        op_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            op_done = 1'b0;
            if (spur_req != spur_done) begin
                op_done = 1'b1;
                spur_done++;
            end else if (resp_en && op_valid) begin
                if (!in_op) begin
                    in_op = 1'b1;
                    wait_cnt = 0;
                    dly_cur = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 3);
                end
                if (wait_cnt == dly_cur) begin
                    op_done = 1'b1;
                    in_op = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else if (resp_en && rand_spur && !op_valid &&
                         $urandom_range(0, 7) == 0) begin
                op_done = 1'b1;
            end
        end
    end

    // Monitor: pops one expectation per op_valid rise, checks stability.
    initial begin
        bit prev_v;
        int vlen;
        logic [85:0] held;
        exp_t e;
        prev_v = 1'b0;
        vlen = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (op_valid && !prev_v) begin
                    vlen = 0;
                    held = {rs1, rs2, rd, rd_in, op_code};
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_op: got op_code %0d expected no op",
                                 op_code);
                    end else begin
                        e = exp_q.pop_front();
                        check("op_fields", {rs1, rs2, rd, op_code},
                              {e.rs1, e.rs2, e.rd, e.op});
                        check("op_rd_in", rd_in, e.imm);
                    end
                end else if (op_valid) begin
                    check("op_hold", {rs1, rs2, rd, rd_in, op_code}, held);
                end
                if (!op_valid) check("op_code_idle", op_code, 0);
                if (op_valid) vlen++;
                if (!op_valid && prev_v) last_len = vlen;
                prev_v = op_valid;
            end
        end
    end

    task automatic run_prog(input bit timing, input int budget);
        int cyc;
        model_prog();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (timing) begin
            check("lat_rd_en", imem_rd_en, 1);
            check("lat_addr", imem_addr, 0);
            repeat (2) @(posedge clk);
            #1;
            check("lat_no_valid_n3", op_valid, 0);
            @(posedge clk);
            #1;
            check("lat_valid_n4", op_valid, 1);
        end
        cyc = 0;
        while (!halted && cyc < budget) begin
            start = rand_spur && busy && ($urandom_range(0, 9) == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("halt_reached", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_addr", imem_addr, exp_pc);
        check("halt_illegal_cnt", illegal_cnt, model_ill);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int cap;
        rst_n = 1'b0;
        start = 1'b0;
        foreach (mem[i]) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {op_valid, imem_rd_en, busy, halted}, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_op_code", op_code, 0);
        check("rst_regs", {rs1, rs2, rd}, 0);
        check("rst_rd_in", rd_in, 0);
        check("rst_illegal", illegal_cnt, 0);
        rst_n = 1'b1;
        model_ill = 0;

        fixed_dly = 4;
        mem[0] = 32'h0031_0533;
        run_prog(1'b1, 100);
        check("add_hold_len", last_len, 5);
        check("add_fields", {rs1, rs2, rd}, {5'd2, 5'd3, 5'd10});

        fixed_dly = -1;
        mem[0] = 32'h4052_0733;
        mem[1] = 32'h0043_B823;
        mem[2] = 32'h0;
        run_prog(1'b0, 100);
        check("sd_fields", {rs1, rd}, {5'd4, 5'd7});
        check("sd_rd_in", rd_in, 64'd16);

        mem[0] = 32'hFE43_BC23;
        mem[1] = 32'h0;
        run_prog(1'b0, 100);
        check("neg_imm", rd_in, 64'hFFFF_FFFF_FFFF_FFF8);

        rand_spur = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NW - 1; i++) mem[i] = rand_word();
            mem[NW-1] = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0;
            run_prog(1'b0, 300);
        end
        rand_spur = 1'b0;

        foreach (mem[i]) mem[i] = 32'hFFFF_FFFF;
        base = model_ill;
        model_prog();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 1400; c++) begin
            if (imem_rd_en) begin
                cap = (base + k > 255) ? 255 : base + k;
                check("wrap_addr", imem_addr, k % NW);
                check("sat_count", illegal_cnt, cap);
                k++;
            end
            @(posedge clk);
            #1;
        end
        check("sat_final", illegal_cnt, model_ill);
        check("sat_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ill = 0;
        check("sat_rst_illegal", illegal_cnt, 0);
        check("sat_rst_busy", busy, 0);

        resp_en = 1'b0;
        mem[0] = 32'h0031_0533;
        mem[1] = 32'h0;
        model_prog();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!op_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mid_valid", op_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_ctl", {op_valid, busy, halted, imem_rd_en}, 0);
        check("mid_rst_op_code", op_code, 0);
        spur_req++;
        repeat (4) @(posedge clk);
        #1;
        check("mid_done_ignored", {op_valid, busy, halted}, 0);
        check("mid_queue", exp_q.size(), 0);
        resp_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
